// File: rtl/mux_n_scan.sv
// mux_n_scan: registered N:1 mux with direct select or auto-scan of all channels,
// dwelling DWELL enabled cycles on each channel.
module mux_n_scan #(
  parameter int N_CH  = 8,
  parameter int WIDTH = 1,
  parameter int SEL_W = 3,
  parameter int DWELL = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH*WIDTH-1:0]   i,
  input  logic [SEL_W-1:0]        s,
  input  logic                    mode,
  input  logic                    en,
  output logic [WIDTH-1:0]        y,
  output logic                    y_valid,
  output logic [SEL_W-1:0]        cur_sel,
  output logic                    wrap,
  output logic                    sel_err
);
  localparam int DW_W = DWELL > 1 ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] P_LAST = SEL_W'(N_CH - 1);
  localparam logic [DW_W-1:0]  D_LAST = DW_W'(DWELL - 1);
  logic [WIDTH-1:0] w_ch [2**SEL_W];
  logic [SEL_W-1:0] r_ptr, w_sel, r_cur;
  logic [DW_W-1:0]  r_dwell;
  logic [WIDTH-1:0] r_y;
  logic             r_valid, r_wrap, r_err, w_s_ok, w_dlast, w_plast;
  // table padded to the full select range so any s indexes safely
  for (genvar k = 0; k < 2**SEL_W; k++) begin : g_ch
    if (k < N_CH) begin : g_used
      assign w_ch[k] = i[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign w_ch[k] = '0;
    end
  end
  assign w_s_ok  = s <= P_LAST;
  assign w_dlast = r_dwell == D_LAST;
  assign w_plast = r_ptr == P_LAST;
  assign w_sel   = mode ? r_ptr : s;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y     <= '0;
      r_valid <= 1'b0;
      r_cur   <= '0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
      r_ptr   <= '0;
      r_dwell <= '0;
    end else begin
      r_valid <= en & (mode | w_s_ok);
      r_err   <= en & ~mode & ~w_s_ok;
      r_wrap  <= en & mode & w_dlast & w_plast;
      if (en) begin
        r_cur   <= w_sel;
        if (mode | w_s_ok) r_y <= w_ch[w_sel];
        r_dwell <= (~mode | w_dlast) ? '0 : r_dwell + 1'b1;
        r_ptr   <= (~mode | (w_dlast & w_plast)) ? '0 : w_dlast ? r_ptr + 1'b1 : r_ptr;
      end
    end
  end
  assign y       = r_y;
  assign y_valid = r_valid;
  assign cur_sel = r_cur;
  assign wrap    = r_wrap;
  assign sel_err = r_err;
endmodule

// File: tb/tb_mux_n_scan.sv
// tb_mux_n_scan: directed vectors into an 8-channel/DWELL=1 and a 5-channel/DWELL=3 instance,
// expected responses queued per instance and checked by independent monitors.
module tb_mux_n_scan;
  typedef struct {
    string      tag;
    logic       y;
    logic       v;
    logic [2:0] cs;
    logic       w;
    logic       e;
  } exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst8 = 1'b1, en8 = 1'b0, mode8 = 1'b0;
  logic [2:0] s8 = '0;
  logic [7:0] i8 = '0;
  logic       y8, v8, w8, e8;
  logic [2:0] cs8;
  logic       rst5 = 1'b1, en5 = 1'b0, mode5 = 1'b0;
  logic [2:0] s5 = '0;
  logic [4:0] i5 = '0;
  logic       y5, v5, w5, e5;
  logic [2:0] cs5;
  int checks = 0, errors = 0;
  exp_t q8[$], q5[$];
  mux_n_scan #(.N_CH(8), .WIDTH(1), .SEL_W(3), .DWELL(1)) dut8 (
    .clk(clk), .rst(rst8), .i(i8), .s(s8), .mode(mode8), .en(en8),
    .y(y8), .y_valid(v8), .cur_sel(cs8), .wrap(w8), .sel_err(e8));
  mux_n_scan #(.N_CH(5), .WIDTH(1), .SEL_W(3), .DWELL(3)) dut5 (
    .clk(clk), .rst(rst5), .i(i5), .s(s5), .mode(mode5), .en(en5),
    .y(y5), .y_valid(v5), .cur_sel(cs5), .wrap(w5), .sel_err(e5));
  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic cmp(input string dut, input exp_t x, input logic y, input logic v,
                     input logic [2:0] cs, input logic w, input logic e);
    chk({dut, " ", x.tag, " y"}, {2'b0, y}, {2'b0, x.y});
    chk({dut, " ", x.tag, " y_valid"}, {2'b0, v}, {2'b0, x.v});
    chk({dut, " ", x.tag, " cur_sel"}, cs, x.cs);
    chk({dut, " ", x.tag, " wrap"}, {2'b0, w}, {2'b0, x.w});
    chk({dut, " ", x.tag, " sel_err"}, {2'b0, e}, {2'b0, x.e});
  endtask
  initial forever begin
    @(posedge clk); #1;
    if (q8.size() > 0) cmp("n8", q8.pop_front(), y8, v8, cs8, w8, e8);
    if (q5.size() > 0) cmp("n5", q5.pop_front(), y5, v5, cs5, w5, e5);
  end
  task automatic step8(input string tg, input logic r, input logic en, input logic m,
                       input logic [2:0] s, input logic [7:0] iv, input logic ey,
                       input logic ev, input logic [2:0] ecs, input logic ew, input logic ee);
    @(negedge clk);
    rst8 = r; en8 = en; mode8 = m; s8 = s; i8 = iv;
    q8.push_back('{tg, ey, ev, ecs, ew, ee});
  endtask
  task automatic step5(input string tg, input logic r, input logic en, input logic m,
                       input logic [2:0] s, input logic [4:0] iv, input logic ey,
                       input logic ev, input logic [2:0] ecs, input logic ew, input logic ee);
    @(negedge clk);
    rst5 = r; en5 = en; mode5 = m; s5 = s; i5 = iv;
    q5.push_back('{tg, ey, ev, ecs, ew, ee});
  endtask
  logic       t2_y   [8] = '{0, 1, 1, 0, 0, 1, 0, 1};
  logic       t3_y   [9] = '{1, 0, 1, 0, 0, 1, 0, 1, 1};
  logic [2:0] t4_cs [16] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 4, 4, 4, 0};
  logic       t4_y  [16] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
  initial begin
    // T1: reset overrides en/mode
    step8("T1", 1, 1, 1, 3'd0, 8'hFF, 0, 0, 3'd0, 0, 0);
    step8("T1", 1, 1, 1, 3'd0, 8'hFF, 0, 0, 3'd0, 0, 0);
    // T2: direct mode
    for (int k = 0; k < 8; k++)
      step8("T2", 0, 1, 0, 3'(k), 8'b1010_0110, t2_y[k], 1, 3'(k), 0, 0);
    // T3: scan of A5, wrap with channel 7
    step8("T3rst", 1, 1, 1, 3'd0, 8'hA5, 0, 0, 3'd0, 0, 0);
    for (int k = 0; k < 9; k++)
      step8("T3", 0, 1, 1, 3'd0, 8'hA5, t3_y[k], 1, 3'(k % 8), k == 7, 0);
    step8("T3hold", 0, 0, 1, 3'd0, 8'hA5, 1, 0, 3'd0, 0, 0);
    // T6: scan to channel 3, one direct cycle, scan restarts at channel 0
    step8("T6rst", 1, 0, 0, 3'd0, 8'hA5, 0, 0, 3'd0, 0, 0);
    for (int k = 0; k < 4; k++)
      step8("T6scan", 0, 1, 1, 3'd0, 8'hA5, t3_y[k], 1, 3'(k), 0, 0);
    step8("T6dir", 0, 1, 0, 3'd6, 8'hA5, 0, 1, 3'd6, 0, 0);
    step8("T6re", 0, 1, 1, 3'd6, 8'hA5, 1, 1, 3'd0, 0, 0);
    step8("T6re", 0, 1, 1, 3'd6, 8'hA5, 0, 1, 3'd1, 0, 0);
    step8("T6end", 0, 0, 0, 3'd0, 8'hA5, 0, 0, 3'd1, 0, 0);
    // T4: N=5, DWELL=3, en dropped for 2 cycles mid-dwell on channel 1
    step5("T4rst", 1, 1, 1, 3'd0, 5'b10110, 0, 0, 3'd0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      step5("T4", 0, 1, 1, 3'd0, 5'b10110, t4_y[k], 1, t4_cs[k], k == 14, 0);
      if (k == 3) begin
        step5("T4off", 0, 0, 1, 3'd0, 5'b10110, 1, 0, 3'd1, 0, 0);
        step5("T4off", 0, 0, 1, 3'd0, 5'b10110, 1, 0, 3'd1, 0, 0);
      end
    end
    // T5: illegal selects hold y and flag sel_err
    step5("T5ok", 0, 1, 0, 3'd3, 5'b10110, 0, 1, 3'd3, 0, 0);
    step5("T5s6", 0, 1, 0, 3'd6, 5'b10110, 0, 0, 3'd6, 0, 1);
    step5("T5s5", 0, 1, 0, 3'd5, 5'b10110, 0, 0, 3'd5, 0, 1);
    step5("T5s2", 0, 1, 0, 3'd2, 5'b10110, 1, 1, 3'd2, 0, 0);
    step5("T5s4", 0, 1, 0, 3'd4, 5'b10110, 1, 1, 3'd4, 0, 0);
    step5("T5s7", 0, 1, 0, 3'd7, 5'b10110, 1, 0, 3'd7, 0, 1);
    step5("T5scan", 0, 1, 1, 3'd7, 5'b10110, 0, 1, 3'd0, 0, 0);
    step5("T5idle", 0, 0, 0, 3'd0, 5'b10110, 0, 0, 3'd0, 0, 0);
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (q8.size() != 0 || q5.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", q8.size() + q5.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
